// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: result = (a * b) mod p, MSB-first interleaved
// shift-and-reduce, one multiplier bit per clock, start/finished handshake.
module mod_mul_serial #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic             o_finished
);

    localparam int W2 = WIDTH + 2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] p_reg, p_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             a_ok_reg, a_ok_next;

    logic [W2-1:0]    p_ext;
    logic [W2-1:0]    t1_raw, t1;
    logic [W2-1:0]    t2_raw, t2;
    logic [W2-1:0]    addend;
    logic             mul_bit;
    logic             unused_hi;

    // An out-of-range multiplicand (a >= p, which includes p <= 1) contributes
    // nothing, so r stays below p and degenerate moduli collapse to zero.
    assign mul_bit = b_reg[cnt_reg] & a_ok_reg;

    genvar gi;
    generate
        for (gi = 0; gi < W2; gi++) begin : g_addend
            if (gi < WIDTH) begin : g_bit
                assign addend[gi] = a_reg[gi] & mul_bit;
            end else begin : g_pad
                assign addend[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        p_ext  = {2'b00, p_reg};
        t1_raw = {1'b0, r_reg, 1'b0};
        t1     = (t1_raw >= p_ext) ? (t1_raw - p_ext) : t1_raw;
        t2_raw = t1 + addend;
        t2     = (t2_raw >= p_ext) ? (t2_raw - p_ext) : t2_raw;
    end

    // Both reductions keep t2 < p, so the two guard bits are always zero here.
    assign unused_hi = |t2[W2-1:WIDTH];

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        p_next      = p_reg;
        a_ok_next   = a_ok_reg;
        r_next      = r_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    a_next     = i_a;
                    b_next     = i_b;
                    p_next     = i_p;
                    a_ok_next  = (i_a < i_p);
                    r_next     = '0;
                    cnt_next   = CW'(WIDTH - 1);
                    state_next = CALC;
                end
            end
            CALC: begin
                r_next = t2[WIDTH-1:0];
                if (cnt_reg == '0) begin
                    result_next = t2[WIDTH-1:0];
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            p_reg      <= '0;
            a_ok_reg   <= 1'b0;
            r_reg      <= '0;
            cnt_reg    <= CW'(WIDTH - 1);
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            p_reg      <= p_next;
            a_ok_reg   <= a_ok_next;
            r_reg      <= r_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    assign o_result   = result_reg;
    assign o_busy     = (state_reg != IDLE);
    assign o_finished = (state_reg == DONE);

endmodule

// File: tb/tb_mod_mul_serial.sv
// Self-checking bench for mod_mul_serial: directed cases at WIDTH=8 and 256,
// then randomized operands checked against a plain (a*b)%p reference.
module tb_mod_mul_serial;

    localparam logic [255:0] SECP_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic         clk = 1'b0;
    logic         rst;
    logic         s8, busy8, fin8;
    logic [7:0]   a8, b8, p8, res8;
    logic         s256, busy256, fin256;
    logic [255:0] a256, b256, p256, res256;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mod_mul_serial #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8),
        .i_a(a8), .i_b(b8), .i_p(p8),
        .o_result(res8), .o_busy(busy8), .o_finished(fin8)
    );

    mod_mul_serial #(.WIDTH(256)) dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(s256),
        .i_a(a256), .i_b(b256), .i_p(p256),
        .o_result(res256), .o_busy(busy256), .o_finished(fin256)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] b,
                                            input logic [255:0] p);
        logic [511:0] prod;
        logic [511:0] rem;
        prod = {256'b0, a} * {256'b0, b};
        rem  = prod % {256'b0, p};
        return rem[255:0];
    endfunction

    // Start in the current cycle; returns in the o_finished cycle with the
    // number of cycles from the start cycle to the pulse.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                       output logic [7:0] res, output int lat);
        a8 = a; b8 = b; p8 = p; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        lat = 1;
        while (fin8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = res8;
    endtask

    task automatic op256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] p,
                         output logic [255:0] res, output int lat);
        a256 = a; b256 = b; p256 = p; s256 = 1'b1;
        tick();
        s256 = 1'b0;
        lat = 1;
        while (fin256 !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        res = res256;
    endtask

    logic [7:0]   r8, ra8, rb8, rp8;
    logic [255:0] r256, ra, rb, rp;
    int           lat, fins, fin_at, prev_fin;

    initial begin
        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0; p8 = '0;
        s256 = 1'b0; a256 = '0; b256 = '0; p256 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_res8", res8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_fin8", fin8, 0);
        chk("rst_res256", res256, 0);
        chk("rst_busy256", busy256, 0);

        // Directed 8-bit cases
        op8(8'd200, 8'd150, 8'd251, r8, lat);
        chk("w8_lat", lat, 9);
        chk("w8_res", r8, 131);
        chk("w8_busy_done", busy8, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("w8_hold_res", res8, 131);
            chk("w8_hold_fin", fin8, 0);
        end
        chk("w8_idle_busy", busy8, 0);
        op8(8'd5, 8'd9, 8'd1, r8, lat);
        chk("p1_res", r8, 0);
        chk("p1_lat", lat, 9);
        tick();
        op8(8'd0, 8'd255, 8'd251, r8, lat);
        chk("a0_res", r8, 0);
        tick();

        // Directed secp256k1 cases
        op256(SECP_P - 1, SECP_P - 1, SECP_P, r256, lat);
        chk("secp_m1sq", r256, 1);
        chk("secp_lat1", lat, 257);
        tick();
        op256(SECP_P - 1, 256'd2, SECP_P, r256, lat);
        chk("secp_x2", r256, SECP_P - 2);
        chk("secp_lat2", lat, 257);
        tick();
        op256(rand256() % SECP_P, 256'd0, SECP_P, r256, lat);
        chk("secp_b0", r256, 0);
        chk("secp_lat3", lat, 257);
        tick();

        // Start pulses and input changes while busy must be ignored
        a256 = 256'd3; b256 = 256'd5; p256 = 256'd7; s256 = 1'b1;
        tick();
        fins = 0; fin_at = -1;
        for (int c = 1; c <= 270; c++) begin
            if (fin256 === 1'b1) begin
                fins++;
                if (fin_at < 0) fin_at = c;
            end
            s256 = (c == 3 || c == 100 || c == 257);
            if (s256) begin
                a256 = rand256(); b256 = rand256(); p256 = rand256();
            end
            tick();
        end
        s256 = 1'b0;
        chk("busy_fins", fins, 1);
        chk("busy_fin_at", fin_at, 257);
        chk("busy_res", res256, 1);
        chk("busy_no_restart", busy256, 0);

        // Reset in the middle of a multiply
        a256 = 256'd3; b256 = 256'd5; p256 = 256'd7; s256 = 1'b1;
        tick();
        s256 = 1'b0;
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_fin", fin256, 0);
        chk("mid_rst_busy", busy256, 0);
        chk("mid_rst_res", res256, 0);
        fins = 0;
        for (int c = 0; c < 300; c++) begin
            if (fin256 === 1'b1) fins++;
            tick();
        end
        chk("mid_rst_no_fin", fins, 0);
        op256(256'd3, 256'd5, 256'd7, r256, lat);
        chk("post_rst_res", r256, 1);
        chk("post_rst_lat", lat, 257);

        // Random 256-bit operands, back-to-back
        prev_fin = cyc;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("r256_idle", busy256, 0);
            rp = rand256();
            if (i % 4 == 3) rp = rp >> ($urandom_range(1, 250));
            if (rp == 0) rp = 256'd1;
            ra = rand256() % rp;
            rb = rand256();
            op256(ra, rb, rp, r256, lat);
            chk("r256_res", r256, ref256(ra, rb, rp));
            chk("r256_period", cyc - prev_fin, 258);
            prev_fin = cyc;
        end

        // Random 8-bit operands, back-to-back
        tick();
        prev_fin = -1;
        for (int i = 0; i < 1000; i++) begin
            rp8 = 8'($urandom_range(1, 255));
            ra8 = 8'($urandom % rp8);
            rb8 = 8'($urandom_range(0, 255));
            op8(ra8, rb8, rp8, r8, lat);
            chk("r8_res", r8, 256'((32'(ra8) * 32'(rb8)) % 32'(rp8)));
            if (prev_fin >= 0) chk("r8_period", cyc - prev_fin, 10);
            prev_fin = cyc;
            tick();
            chk("r8_idle", busy8, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_mul_serial.md
# mod_mul_serial

Bit-serial modular multiplier computing o_result = (i_a · i_b) mod i_p with a start/finished handshake. It is the responder end of the start/finish protocol that the point add, point double and scalar-multiply controllers drive. It is the shared multiply primitive underneath those controllers. Each multiply uses MSB-first interleaved shift-and-reduce: one multiplier bit per clock, no DSP multipliers.

## Interface
- WIDTH, 256: operand, modulus and result width in bits.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  request pulse; sampled only in IDLE.
- i_a  input  WIDTH  multiplicand; must satisfy i_a < i_p.
- i_b  input  WIDTH  multiplier; any value.
- i_p  input  WIDTH  modulus; must satisfy i_p ≥ 1.
- o_result  output  WIDTH  product mod p. Valid from the o_finished cycle and held until the next accepted start.
- o_busy  output  1  high from the cycle after acceptance through the o_finished cycle.
- o_finished  output  1  single-cycle completion pulse.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - o_busy=0.
  - On i_start=1, latch i_a, i_b and i_p into internal registers a_q, b_q and p_q.
  - Clear the accumulator r to 0, set the bit counter cnt to WIDTH-1, and go to CALC.
  - Later changes on the inputs have no effect on the running operation.
- CALC, one iteration per cycle:
  - t1 = 2r. If t1 ≥ p_q, subtract p_q.
  - t2 = t1 + (b_q[cnt] ? a_q : 0). If t2 ≥ p_q, subtract p_q.
  - r ← t2.
  - If cnt==0, load o_result ← t2 and go to DONE. Otherwise cnt ← cnt-1.
- DONE: o_finished=1 for exactly this cycle, then IDLE unconditionally.
- Internal datapath width is WIDTH+2 bits so that 2r and t1+a_q never overflow.
- Invariant: r < p_q after every iteration. A competent implementation uses two compare/subtract stages, both in the same cycle.
- i_start is ignored in CALC and DONE; there is no queueing. Upstream must wait for o_finished before asserting i_start again.
- Out-of-contract inputs (i_a ≥ i_p, or i_p = 0):
  - o_result is unspecified.
  - Latency and handshake timing are unchanged.
  - The FSM must never hang.
- p = 1 yields 0 naturally.
- Reset:
  - state=IDLE, r=0, cnt=WIDTH-1, o_result=0, o_finished=0, o_busy=0.
  - Reset mid-operation abandons the multiply and emits no o_finished pulse.

## Timing
- Cycle 0: i_start=1 in IDLE, sampled at the end of cycle 0.
- Cycles 1..WIDTH: CALC with o_busy=1. Cycle k processes bit b_q[WIDTH-k].
- Cycle WIDTH+1: DONE, with o_finished=1, o_busy=1 and o_result valid.
- Cycle WIDTH+2: IDLE, o_busy=0. An i_start here is accepted.
- Latency from the start cycle to o_finished is WIDTH+1 cycles (257 at the default width).
- Back-to-back operation costs WIDTH+2 cycles per multiply.
- o_result changes only on the edge entering DONE, or on reset.

## Test plan
- WIDTH=8, a=200, b=150, p=251:
  - o_finished pulses exactly once, in cycle 9 after the start cycle.
  - o_result=131 and stays stable after the pulse.
- WIDTH=256, p = secp256k1 prime 2^256-2^32-977:
  - a=b=p-1 → o_result=1.
  - a=p-1, b=2 → o_result=p-2.
  - b=0 → o_result=0.
  - All complete in 257 cycles.
- WIDTH=8, a=5, b=9, p=1 → o_result=0. a=0, b=255, p=251 → o_result=0.
- Busy and input-change check:
  - Pulse i_start and change i_a/i_b/i_p at cycles 3, 100 and 257 of a 256-bit multiply (a=3, b=5, p=7).
  - Required: only one o_finished, o_result=1, and no second operation starts.
- Reset mid-operation:
  - Assert i_rst for one cycle at cycle 50 of a multiply.
  - Required: no o_finished, o_result=0, o_busy=0 on the next cycle.
  - A new start (a=3, b=5, p=7) afterwards yields o_result=1 at the normal latency.
- Back-to-back: assert i_start in the cycle after each o_finished for 1000 random in-contract operand sets against a reference model. All results must match, with a period of exactly WIDTH+2 cycles.
